dcache_dm: RTL

- Direct-mapped, write-back, write-allocate data cache.
- Sits between the pipelined datapath's memory stage and a slow backing data memory.
- Answers M-stage loads and stores in the same cycle on a hit.
- On a miss, asserts StallM and runs a writeback/refill handshake with the backing memory.

---
 rtl/dcache_dm.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back/write-allocate data cache (optional stats: DCACHE_STATS_EN)
module dcache_dm #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MemReq,
  output logic                  MemWe,
  output logic [DATA_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWData,
  input  logic                  MemReady,
  input  logic [DATA_WIDTH-1:0] MemRData
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           HitCount,
  output logic [31:0]           MissCount
`endif
);

  localparam int TAG_BITS = DATA_WIDTH - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WB   = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]            state;
  logic [LINES-1:0]      valid_q;
  logic [LINES-1:0]      dirty_q;
  logic [TAG_BITS-1:0]   tag_arr  [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES];

  // Miss address is captured so a flushed access cannot disturb an in-flight transfer.
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  access;
  logic                  hit;
  logic                  store_hit;
  logic                  miss;
  logic                  fill_done;
  logic                  unused_offset;

  assign index         = ALUResultM[INDEX_BITS+1:2];
  assign tag           = ALUResultM[DATA_WIDTH-1:INDEX_BITS+2];
  assign unused_offset = ^ALUResultM[1:0];
  assign access        = MemReadM | MemWriteM;
  assign hit           = access && (state == IDLE) && valid_q[index] && (tag_arr[index] == tag);
  assign store_hit     = hit && MemWriteM;
  assign miss          = access && (state == IDLE) && !hit;
  assign fill_done     = (state == FILL) && MemReady;

  assign ReadDataM = (hit && MemReadM) ? data_arr[index] : '0;
  assign StallM    = access && !hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_hit) begin
            dirty_q[index] <= 1'b1;
          end
          if (miss) begin
            miss_idx <= index;
            miss_tag <= tag;
            state    <= (valid_q[index] && dirty_q[index]) ? WB : FILL;
          end
        end
        WB: begin
          if (MemReady) begin
            state <= FILL;
          end
        end
        FILL: begin
          if (MemReady) begin
            valid_q[miss_idx] <= 1'b1;
            dirty_q[miss_idx] <= 1'b0;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (store_hit) begin
      data_arr[index] <= WriteDataM;
    end
    if (fill_done) begin
      data_arr[miss_idx] <= MemRData;
      tag_arr[miss_idx]  <= miss_tag;
    end
  end

  always_comb begin
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = '0;
    MemWData = '0;
    case (state)
      WB: begin
        MemReq   = 1'b1;
        MemWe    = 1'b1;
        MemAddr  = {tag_arr[miss_idx], miss_idx, 2'b00};
        MemWData = data_arr[miss_idx];
      end
      FILL: begin
        MemReq  = 1'b1;
        MemAddr = {miss_tag, miss_idx, 2'b00};
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  // retry_q marks the replayed cycle after a fill; that hit belongs to a miss, not a hit.
  logic retry_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      retry_q   <= 1'b0;
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      retry_q <= fill_done;
      if (hit && !retry_q && (HitCount != 32'hFFFF_FFFF)) begin
        HitCount <= HitCount + 32'd1;
      end
      if (miss && (MissCount != 32'hFFFF_FFFF)) begin
        MissCount <= MissCount + 32'd1;
      end
    end
  end
`endif

endmodule
